inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
- REQ-001: clk  in  1  sole clock; all state updates on rising edge.
- REQ-002: rst  in  1  synchronous, active-high reset.
- REQ-003: icache_ce  out  1  instruction-cache enable.
- REQ-004: icache_addr  out  `Inst_Addr_Width  byte address of the current fetch (the PC).
- REQ-005: icache_inst  in  `Inst_Width  instruction returned by the cache in the same cycle, already in standard bit order.
- REQ-006: icache_enable  in  1  cache-data-valid qualifier.
- REQ-007: redirect_valid  in  1  flush and redirect request from the branch/commit logic.
- REQ-008: redirect_pc  in  `Inst_Addr_Width  redirect target.
- REQ-009: dec_valid  out  1  queue head is valid for decode.
- REQ-010: dec_inst  out  `Inst_Width  head instruction.
- REQ-011: dec_pc  out  `Inst_Addr_Width  head PC.
- REQ-012: dec_ready  in  1  decode accepts the head this cycle.
- REQ-013: Parameter QUEUE_DEPTH, default 4, fetch-queue entries (power of 2, at least 2).
- REQ-014: Parameter RESET_PC, default 0, first fetch address.

Function
- REQ-015: FSM states: BOOT, RUN, HALT; reset enters BOOT; BOOT goes to RUN unconditionally after 1 cycle.
- REQ-016: icache_ce SHALL be 1 only in RUN, with count < QUEUE_DEPTH and redirect_valid low; icache_addr SHALL always equal pc.
- REQ-017: A fetch fires when icache_ce and icache_enable are both 1: {pc, icache_inst} is enqueued at the tail and pc advances to pc+4 (modulo 2^`Inst_Addr_Width wrap-around).
- REQ-018: icache_ce high with icache_enable low: no enqueue, pc holds, retry next cycle.
- REQ-019: dec_valid = (count != 0); dec_inst/dec_pc SHALL show the head entry; a dequeue occurs when dec_valid and dec_ready are both 1.
- REQ-020: Fetch-to-decode latency: an instruction fetched in cycle N is visible on dec_* in cycle N+1 at the earliest.
- REQ-021: Simultaneous enqueue and dequeue leaves count unchanged; head/tail pointers wrap modulo QUEUE_DEPTH.
- REQ-022: Full (count == QUEUE_DEPTH) SHALL block fetch for that cycle even if dec_ready is 1; fetch resumes the cycle after a dequeue.
- REQ-023: redirect_valid has highest priority: the queue is emptied, pc <= {redirect_pc[MSB:2], 2'b00}, no fetch occurs, and the FSM goes to RUN from any state including HALT; on the following cycle dec_valid = 0.
- REQ-024: Fetched instruction == 32'h0000_0000: it is not enqueued, pc holds, FSM goes to HALT; HALT keeps icache_ce = 0 while the queue keeps draining.
- REQ-025: pc[1:0] SHALL be 2'b00 at all times.

Reset
- REQ-026: Reset SHALL set pc = RESET_PC, count = 0, head = tail = 0, FSM = BOOT, icache_ce = 0, dec_valid = 0; dec_inst and dec_pc read 0 while the queue is empty.
- REQ-027: Reset asserted mid-operation SHALL discard all queued entries and override redirect_valid.

Configuration
- REQ-028: Macro FETCH_JAL_PREDICT_EN defined: a fetched instruction whose opcode [6:0] == 7'b1101111 is enqueued and the next pc = pc + sign-extended {i[31], i[19:12], i[20], i[30:21], 1'b0} instead of pc+4.
- REQ-029: FETCH_JAL_PREDICT_EN undefined: the next pc is always pc+4, with no JAL decode logic present.

Structure
- REQ-030: FSM state encodings, the JAL opcode constant and the halt instruction value SHALL live in the shared defines file alongside `Inst_Width/`Inst_Addr_Width.
- REQ-031: The queue SHALL be a sub-module fetch_queue (parameterised depth/width, push/pop/flush, full/empty); inst_fetch holds the pc and the FSM.

Verification
- REQ-032: Reset, cache program 0x00000013 x8, dec_ready = 1 -> icache_addr 0,4,8,... starting the cycle after BOOT; dec_pc 0,4,8 one cycle behind.
- REQ-033: dec_ready = 0 for 10 cycles -> exactly 4 entries queued, icache_ce = 0, pc = 0x10; raise dec_ready -> PCs 0x0,0x4,0x8,0xC drain in order with no gaps or duplicates.
- REQ-034: Queue holding 3 entries, redirect_valid = 1 with redirect_pc = 0x23 -> next cycle dec_valid = 0, icache_addr = 0x20.
- REQ-035: Word at 0x18 = 0 -> dec stream ends at pc 0x14, FSM HALT; redirect to 0x0 -> fetching restarts at 0x0.
- REQ-036: FETCH_JAL_PREDICT_EN defined, 0x008000EF (jal ra,+8) at 0x4 -> fetch sequence 0x0, 0x4, 0xC; macro undefined -> 0x0, 0x4, 0x8.
- REQ-037: icache_enable held 0 for 3 cycles at pc 0x8 -> no enqueue and pc stays 0x8; on release 0x8 is fetched once.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: widths, FSM states, JAL opcode and halt word.
// Optional JAL next-pc prediction is enabled by defining FETCH_JAL_PREDICT_EN.
`ifndef Inst_Width
`define Inst_Width 32
`endif
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif

package inst_fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [6:0]             JAL_OPCODE = 7'b1101111;
   localparam logic [`Inst_Width-1:0] HALT_INST  = '0;

`ifdef FETCH_JAL_PREDICT_EN
   // J-type immediate, sign-extended to the address width
   function automatic logic [`Inst_Addr_Width-1:0] jal_offset(input logic [`Inst_Width-1:0] i_inst);
      logic [20:0] w_imm;
      w_imm = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      return {{(`Inst_Addr_Width-21){w_imm[20]}}, w_imm};
   endfunction
`endif

endpackage

// File: rtl/inst_fetch_queue.sv
// Fetch queue: power-of-2 depth circular buffer with push/pop/flush.
// Head data reads as zero while empty. FETCH_JAL_PREDICT_EN has no effect here.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_rdata = o_empty ? '0 : r_mem[r_head];

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= i_wdata;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: pc register, BOOT/RUN/HALT FSM and a fetch queue to decode.
// Defining FETCH_JAL_PREDICT_EN redirects the next pc to JAL targets.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned                 QUEUE_DEPTH = 4,
   parameter logic [`Inst_Addr_Width-1:0] RESET_PC    = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        icache_ce,
   output logic [`Inst_Addr_Width-1:0] icache_addr,
   input  logic [`Inst_Width-1:0]      icache_inst,
   input  logic                        icache_enable,
   input  logic                        redirect_valid,
   input  logic [`Inst_Addr_Width-1:0] redirect_pc,
   output logic                        dec_valid,
   output logic [`Inst_Width-1:0]      dec_inst,
   output logic [`Inst_Addr_Width-1:0] dec_pc,
   input  logic                        dec_ready
);
   localparam int unsigned ENTRY_W = `Inst_Addr_Width + `Inst_Width;

   fetch_state_e                r_state;
   fetch_state_e                w_state_next;
   logic [`Inst_Addr_Width-1:0] r_pc;
   logic [`Inst_Addr_Width-1:0] w_pc_next;
   logic [`Inst_Addr_Width-1:0] w_pc_seq;
   logic [`Inst_Addr_Width-1:0] w_redirect_pc;
   logic                        w_ce;
   logic                        w_fire;
   logic                        w_halt;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_full;
   logic                        w_empty;
   logic [ENTRY_W-1:0]          w_head;

   assign w_ce          = (r_state == ST_RUN) && !w_full && !redirect_valid;
   assign w_fire        = w_ce & icache_enable;
   assign w_halt        = w_fire && (icache_inst == HALT_INST);
   assign w_push        = w_fire & ~w_halt;
   assign w_pop         = dec_valid & dec_ready;
   assign w_redirect_pc = redirect_pc & ~`Inst_Addr_Width'(3);

   assign icache_ce   = w_ce;
   assign icache_addr = r_pc;
   assign dec_valid   = ~w_empty;
   assign dec_pc      = w_head[ENTRY_W-1:`Inst_Width];
   assign dec_inst    = w_head[`Inst_Width-1:0];

`ifdef FETCH_JAL_PREDICT_EN
   assign w_pc_seq = (icache_inst[6:0] == JAL_OPCODE) ? (r_pc + jal_offset(icache_inst))
                                                      : (r_pc + `Inst_Addr_Width'(4));
`else
   assign w_pc_seq = r_pc + `Inst_Addr_Width'(4);
`endif

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      case (r_state)
         ST_BOOT: w_state_next = ST_RUN;
         ST_RUN:  if (w_halt) w_state_next = ST_HALT;
         ST_HALT: w_state_next = ST_HALT;
         default: w_state_next = ST_BOOT;
      endcase
      if (w_push) w_pc_next = w_pc_seq;
      if (redirect_valid) begin
         w_state_next = ST_RUN;
         w_pc_next    = w_redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_PC & ~`Inst_Addr_Width'(3);
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_wdata ({r_pc, icache_inst}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a word-addressed instruction memory model.
// Expected JAL behaviour follows FETCH_JAL_PREDICT_EN.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        icache_ce;
   logic [31:0] icache_addr;
   logic [31:0] icache_inst;
   logic        icache_enable;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_ready;

   logic [31:0] mem [64];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   assign icache_inst = mem[icache_addr[7:2]];

   inst_fetch #(
      .QUEUE_DEPTH (4),
      .RESET_PC    (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .icache_ce      (icache_ce),
      .icache_addr    (icache_addr),
      .icache_inst    (icache_inst),
      .icache_enable  (icache_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      tick();
      chk("rst_ce", 32'(icache_ce), 32'd0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_addr", icache_addr, 32'h0);
      chk("rst_inst", dec_inst, 32'h0);
      chk("rst_pc", dec_pc, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
      rst = 1'b1; icache_enable = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; dec_ready = 1'b1;

      // streaming fetch with decode always ready
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("stream_addr", icache_addr, 32'(4 * (k - 1)));
         if (k == 1) chk("stream_v0", 32'(dec_valid), 32'd0);
         else begin
            chk("stream_pc", dec_pc, 32'(4 * (k - 2)));
            chk("stream_inst", dec_inst, 32'h0000_0013);
         end
      end

      // backpressure fills the queue, then drains in order
      dec_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      chk("full_ce", 32'(icache_ce), 32'd0);
      chk("full_addr", icache_addr, 32'h10);
      chk("full_head", dec_pc, 32'h0);
      dec_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("drain_pc", dec_pc, 32'(4 * k));
         if (k == 1) chk("resume_ce", 32'(icache_ce), 32'd1);
      end

      // redirect with 3 entries queued
      dec_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      chk("pre_redir_addr", icache_addr, 32'hC);
      redirect_valid = 1'b1; redirect_pc = 32'h23;
      #1;
      chk("redir_ce", 32'(icache_ce), 32'd0);
      tick();
      redirect_valid = 1'b0;
      chk("redir_valid", 32'(dec_valid), 32'd0);
      chk("redir_addr", icache_addr, 32'h20);
      chk("redir_inst", dec_inst, 32'h0);
      tick();
      chk("redir_fetch", dec_pc, 32'h20);

      // halt word at 0x18, then redirect restarts
      mem[6] = 32'h0;
      dec_ready = 1'b1;
      do_reset();
      repeat (7) tick();
      chk("halt_last_pc", dec_pc, 32'h14);
      tick();
      chk("halt_ce", 32'(icache_ce), 32'd0);
      chk("halt_valid", 32'(dec_valid), 32'd0);
      chk("halt_addr", icache_addr, 32'h18);
      tick();
      chk("halt_hold", 32'(icache_ce), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("restart_ce", 32'(icache_ce), 32'd1);
      chk("restart_addr", icache_addr, 32'h0);
      tick();
      chk("restart_pc", dec_pc, 32'h0);
      chk("restart_next", icache_addr, 32'h4);
      mem[6] = 32'h0000_0013;

      // jal ra,+8 at 0x4
      mem[1] = 32'h0080_00EF;
      do_reset();
      repeat (3) tick();
`ifdef FETCH_JAL_PREDICT_EN
      chk("jal_addr", icache_addr, 32'hC);
`else
      chk("jal_addr", icache_addr, 32'h8);
`endif
      chk("jal_inst", dec_inst, 32'h0080_00EF);
      chk("jal_pc", dec_pc, 32'h4);
      mem[1] = 32'h0000_0013;

      // cache not ready for 3 cycles at 0x8
      do_reset();
      repeat (3) tick();
      chk("stall_start", icache_addr, 32'h8);
      icache_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_addr", icache_addr, 32'h8);
         chk("stall_ce", 32'(icache_ce), 32'd1);
      end
      chk("stall_empty", 32'(dec_valid), 32'd0);
      icache_enable = 1'b1;
      tick();
      chk("stall_fetch", dec_pc, 32'h8);
      chk("stall_next", icache_addr, 32'hC);
      tick();
      chk("stall_once", dec_pc, 32'hC);

      // pc wraps around the top of the address space
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("wrap_addr", icache_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_next", icache_addr, 32'h0);
      chk("wrap_pc", dec_pc, 32'hFFFF_FFFC);

      // reset overrides a simultaneous redirect mid-operation
      dec_ready = 1'b0;
      tick(); tick();
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      chk("midrst_valid", 32'(dec_valid), 32'd0);
      chk("midrst_addr", icache_addr, 32'h0);
      chk("midrst_ce", 32'(icache_ce), 32'd0);
      rst = 1'b0; redirect_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
